// File: rtl/line_pkg.sv
// line_pkg: shared FSM states, coordinate width default and error width derivation for the line rasterizer.
package line_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
  localparam int COORD_W_DEF = 8;
  function automatic int err_w(input int cw);
    return cw + 2;
  endfunction
endpackage

// File: rtl/line_step.sv
// line_step: one combinational Bresenham step; both axis tests use the incoming error term.
module line_step import line_pkg::*; #(
  parameter int COORD_W = COORD_W_DEF,
  localparam int ERR_W = err_w(COORD_W)
) (
  input  logic [COORD_W-1:0]      x_i,
  input  logic [COORD_W-1:0]      y_i,
  input  logic signed [ERR_W-1:0] err_i,
  input  logic signed [ERR_W-1:0] dx_i,
  input  logic signed [ERR_W-1:0] dy_i,
  input  logic                    sx_neg_i,
  input  logic                    sy_neg_i,
  output logic [COORD_W-1:0]      x_o,
  output logic [COORD_W-1:0]      y_o,
  output logic signed [ERR_W-1:0] err_o
);
  logic signed [ERR_W:0] e2, dx_ext, dy_ext;
  logic step_x, step_y;
  always_comb begin
    e2     = {err_i, 1'b0};
    dx_ext = dx_i;
    dy_ext = dy_i;
    step_x = e2 >= dy_ext;
    step_y = e2 <= dx_ext;
    err_o  = err_i + (step_x ? dy_i : '0) + (step_y ? dx_i : '0);
    x_o    = step_x ? (sx_neg_i ? x_i - 1'b1 : x_i + 1'b1) : x_i;
    y_o    = step_y ? (sy_neg_i ? y_i - 1'b1 : y_i + 1'b1) : y_i;
  end
endmodule

// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line walker emitting one pixel per valid/ready handshake.
module line_rasterizer import line_pkg::*; #(
  parameter int COORD_W = COORD_W_DEF,
  localparam int ERR_W = err_w(COORD_W)
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               EN,
  input  logic               ABORT,
  input  logic [COORD_W-1:0] X_1,
  input  logic [COORD_W-1:0] Y_1,
  input  logic [COORD_W-1:0] X_2,
  input  logic [COORD_W-1:0] Y_2,
  output logic [COORD_W-1:0] X_Out,
  output logic [COORD_W-1:0] Y_Out,
  output logic               PIX_VALID,
  input  logic               PIX_READY,
  output logic               BUSY,
  output logic               finish
);
  state_t state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, x2_q, x2_d, y2_q, y2_d, nx, ny;
  logic signed [ERR_W-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d, nerr;
  logic sxn_q, sxn_d, syn_q, syn_d, at_end;

  line_step #(.COORD_W(COORD_W)) u_step (
    .x_i(x_q), .y_i(y_q), .err_i(err_q), .dx_i(dx_q), .dy_i(dy_q),
    .sx_neg_i(sxn_q), .sy_neg_i(syn_q), .x_o(nx), .y_o(ny), .err_o(nerr)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x2_d    = x2_q;
    y2_d    = y2_q;
    err_d   = err_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    at_end  = (x_q == x2_q) && (y_q == y2_q);
    case (state_q)
      IDLE: if (EN && !ABORT) begin
        state_d = SETUP;
        x_d     = X_1;
        y_d     = Y_1;
        x2_d    = X_2;
        y2_d    = Y_2;
      end
      SETUP: begin
        sxn_d   = x2_q < x_q;
        syn_d   = y2_q < y_q;
        dx_d    = ERR_W'(sxn_d ? x_q - x2_q : x2_q - x_q);
        dy_d    = -ERR_W'(syn_d ? y_q - y2_q : y2_q - y_q);
        err_d   = dx_d + dy_d;
        state_d = DRAW;
      end
      DRAW: if (PIX_READY) begin
        if (at_end) state_d = DONE;
        else begin
          x_d   = nx;
          y_d   = ny;
          err_d = nerr;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ABORT && state_q != IDLE) state_d = IDLE;
    PIX_VALID = state_q == DRAW;
    BUSY      = state_q != IDLE;
    finish    = (state_q == DONE) && !ABORT;
    X_Out     = x_q;
    Y_Out     = y_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      err_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      err_q   <= err_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
    end
  end
endmodule

// File: tb/tb_line_rasterizer.sv
// tb_line_rasterizer: table-driven line vectors plus hand-written abort, reset and busy-EN sequences.
module tb_line_rasterizer;
  logic ACLK = 1'b0, ARESET = 1'b0, EN = 1'b0, ABORT = 1'b0, PIX_READY = 1'b0;
  logic [7:0] X_1 = '0, Y_1 = '0, X_2 = '0, Y_2 = '0, X_Out, Y_Out;
  logic PIX_VALID, BUSY, finish;
  int tests = 0, fails = 0;
  logic [7:0] exp_x [300];
  logic [7:0] exp_y [300];

  typedef struct {
    int x1, y1, x2, y2, n;
    bit stall;
    logic [0:8][7:0] ex, ey;
  } vec_t;
  vec_t vecs [7];

  line_rasterizer #(.COORD_W(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .EN(EN), .ABORT(ABORT),
    .X_1(X_1), .Y_1(Y_1), .X_2(X_2), .Y_2(Y_2),
    .X_Out(X_Out), .Y_Out(Y_Out), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .BUSY(BUSY), .finish(finish)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic run_line(input int x1, input int y1, input int x2, input int y2,
                          input int n, input bit stall, input string nm);
    int k;
    bit seen_fin;
    @(negedge ACLK);
    X_1 = 8'(x1); Y_1 = 8'(y1); X_2 = 8'(x2); Y_2 = 8'(y2);
    EN = 1'b1;
    PIX_READY = 1'b0;
    @(negedge ACLK);
    EN = 1'b0;
    chk({nm, " setup valid"}, PIX_VALID, 0);
    chk({nm, " setup busy"}, BUSY, 1);
    @(negedge ACLK);
    chk({nm, " first valid"}, PIX_VALID, 1);
    k = 0;
    seen_fin = 0;
    for (int cyc = 0; cyc < 4000 && !seen_fin; cyc++) begin
      if (cyc > 0) @(negedge ACLK);
      if (finish) begin
        seen_fin = 1;
        chk({nm, " pixel count"}, k, n);
        chk({nm, " valid at finish"}, PIX_VALID, 0);
        if (!stall) chk({nm, " finish cycle"}, cyc, n);
      end else if (PIX_VALID) begin
        if (k >= n) chk({nm, " extra pixel"}, k, n - 1);
        else begin
          chk($sformatf("%s x[%0d]", nm, k), X_Out, exp_x[k]);
          chk($sformatf("%s y[%0d]", nm, k), Y_Out, exp_y[k]);
        end
        PIX_READY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (PIX_READY) k++;
      end else chk({nm, " valid dropped"}, PIX_VALID, 1);
    end
    PIX_READY = 1'b0;
    if (!seen_fin) chk({nm, " finish timeout"}, 0, 1);
    @(negedge ACLK);
    chk({nm, " busy after"}, BUSY, 0);
    chk({nm, " finish one cycle"}, finish, 0);
  endtask

  initial begin
    vecs[0] = '{0, 0, 7, 3, 8, 1'b0,
      {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0},
      {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd0}};
    vecs[1] = '{5, 5, 5, 5, 1, 1'b0,
      {8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
      {8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[2] = '{10, 2, 2, 10, 9, 1'b1,
      {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2},
      {8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10}};
    vecs[3] = '{3, 0, 1, 4, 5, 1'b0,
      {8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
      {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[4] = '{7, 3, 0, 0, 8, 1'b1,
      {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0},
      {8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0}};
    vecs[5] = '{1, 1, 1, 4, 4, 1'b0,
      {8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
      {8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[6] = '{4, 6, 0, 6, 5, 1'b0,
      {8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
      {8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0}};

    #3 ARESET = 1'b1;
    #1;
    chk("reset valid", PIX_VALID, 0);
    chk("reset busy", BUSY, 0);
    chk("reset finish", finish, 0);
    chk("reset x", X_Out, 0);
    chk("reset y", Y_Out, 0);
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 9; j++) begin
        exp_x[j] = vecs[i].ex[j];
        exp_y[j] = vecs[i].ey[j];
      end
      run_line(vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2, vecs[i].n, vecs[i].stall,
               $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 256; i++) begin
      exp_x[i] = 8'(255 - i);
      exp_y[i] = 8'(i);
    end
    run_line(255, 0, 0, 255, 256, 1'b0, "diag_down");
    for (int i = 0; i < 256; i++) begin
      exp_x[i] = 8'(i);
      exp_y[i] = 8'(255 - i);
    end
    run_line(0, 255, 255, 0, 256, 1'b0, "diag_up");

    // abort on the third pixel of a horizontal line
    @(negedge ACLK);
    X_1 = 8'd0; Y_1 = 8'd0; X_2 = 8'd20; Y_2 = 8'd0;
    EN = 1'b1;
    PIX_READY = 1'b1;
    @(negedge ACLK);
    EN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      chk("abort line valid", PIX_VALID, 1);
      chk("abort line x", X_Out, k);
    end
    ABORT = 1'b1;
    #1 chk("abort cycle finish", finish, 0);
    @(negedge ACLK);
    chk("abort valid", PIX_VALID, 0);
    chk("abort finish", finish, 0);
    chk("abort busy", BUSY, 0);
    ABORT = 1'b0;
    PIX_READY = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp_x[j] = 8'd1;
      exp_y[j] = 8'(j + 1);
    end
    run_line(1, 1, 1, 4, 4, 1'b0, "after_abort");

    // ABORT in IDLE wins over EN
    @(negedge ACLK);
    X_1 = 8'd3; Y_1 = 8'd3; X_2 = 8'd4; Y_2 = 8'd4;
    EN = 1'b1;
    ABORT = 1'b1;
    @(negedge ACLK);
    EN = 1'b0;
    ABORT = 1'b0;
    chk("idle abort busy", BUSY, 0);
    @(negedge ACLK);
    chk("idle abort valid", PIX_VALID, 0);

    // EN while busy is ignored, then reset mid-line
    @(negedge ACLK);
    X_1 = 8'd0; Y_1 = 8'd0; X_2 = 8'd20; Y_2 = 8'd0;
    EN = 1'b1;
    PIX_READY = 1'b1;
    @(negedge ACLK);
    EN = 1'b0;
    @(negedge ACLK);
    chk("busy-en x0", X_Out, 0);
    @(negedge ACLK);
    chk("busy-en x1", X_Out, 1);
    X_1 = 8'd50; Y_1 = 8'd50; X_2 = 8'd60; Y_2 = 8'd60;
    EN = 1'b1;
    @(negedge ACLK);
    EN = 1'b0;
    chk("busy-en x2", X_Out, 2);
    chk("busy-en busy", BUSY, 1);
    @(negedge ACLK);
    chk("busy-en x3", X_Out, 3);
    chk("busy-en y3", Y_Out, 0);
    ARESET = 1'b1;
    #1;
    chk("mid reset valid", PIX_VALID, 0);
    chk("mid reset busy", BUSY, 0);
    chk("mid reset finish", finish, 0);
    chk("mid reset x", X_Out, 0);
    chk("mid reset y", Y_Out, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      chk("post reset valid", PIX_VALID, 0);
      chk("post reset finish", finish, 0);
      chk("post reset busy", BUSY, 0);
    end
    PIX_READY = 1'b0;
    for (int j = 0; j < 4; j++) begin
      exp_x[j] = 8'd1;
      exp_y[j] = 8'(j + 1);
    end
    run_line(1, 1, 1, 4, 4, 1'b1, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/line_rasterizer.md
LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 SHALL have parameter: COORD_W, 8, coordinate width in bits (unsigned coordinates, 4..16).
REQ-002 SHALL have parameter: ERR_W, COORD_W+2, signed width of delta and error registers (derived, not overridden).
REQ-003 SHALL have port: ACLK  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port: ARESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: EN  in  1  start request, sampled only in IDLE.
REQ-006 SHALL have port: ABORT  in  1  cancel current line.
REQ-007 SHALL have ports: X_1, Y_1  in  COORD_W  start point; X_2, Y_2  in  COORD_W  end point.
REQ-008 SHALL have ports: X_Out, Y_Out  out  COORD_W  current pixel coordinate.
REQ-009 SHALL have port: PIX_VALID  out  1  X_Out/Y_Out hold a pixel to be consumed.
REQ-010 SHALL have port: PIX_READY  in  1  consumer accepts pixel when PIX_VALID & PIX_READY.
REQ-011 SHALL have ports: BUSY  out  1  high in any state except IDLE; finish  out  1  one-cycle pulse on line completion.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, DRAW, DONE.
REQ-013 SHALL in IDLE, on EN=1 and ABORT=0, latch X_1/Y_1/X_2/Y_2 and go to SETUP; inputs are not sampled again until next IDLE.
REQ-014 SHALL in SETUP (one cycle) compute dx=|X_2-X_1|, dy=-|Y_2-Y_1|, sx/sy=+1 or -1 (sign +1 when equal), err=dx+dy, all ERR_W signed, then go to DRAW.
REQ-015 SHALL in DRAW drive PIX_VALID=1 with current point; first pixel equals (X_1,Y_1), first PIX_VALID two cycles after the EN cycle.
REQ-016 SHALL hold X_Out/Y_Out/PIX_VALID stable while PIX_VALID=1 and PIX_READY=0.
REQ-017 SHALL on handshake, if current point equals end point, go to DONE; else step: e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy; both tests use pre-step err.
REQ-018 SHALL cover all eight octants; pixel count equals max(dx,-dy)+1; steps never wrap below 0 or above 2^COORD_W-1.
REQ-019 SHALL sustain one pixel per cycle when PIX_READY is held high.
REQ-020 SHALL in DONE assert finish for exactly one cycle, PIX_VALID=0, then return to IDLE; BUSY=0 from that next cycle.
REQ-021 SHALL treat X_1=X_2 and Y_1=Y_2 as a single-pixel line (one handshake, then finish).
REQ-022 SHALL ignore EN while BUSY=1.
REQ-023 SHALL on ABORT=1 in SETUP/DRAW/DONE go to IDLE next cycle with PIX_VALID=0 and no finish pulse; ABORT in IDLE suppresses EN in the same cycle.

Reset
REQ-024 SHALL on ARESET=1 immediately force state IDLE, PIX_VALID=0, BUSY=0, finish=0, X_Out=0, Y_Out=0, internal err/deltas=0.
REQ-025 SHALL on reset mid-line discard the line; no finish and no further pixels after deassertion until a new EN.

Structure
REQ-026 SHALL place the state enumeration, COORD_W default and ERR_W derivation in shared package line_pkg.
REQ-027 SHALL implement the combinational Bresenham step (REQ-017) in one sub-module line_step; FSM, registers and handshake stay in line_rasterizer.

Verification
REQ-028 SHALL verify: (0,0)->(7,3), PIX_READY=1 -> 8 pixels (0,0)(1,0)(2,1)(3,1)(4,2)(5,2)(6,3)(7,3) on consecutive cycles, finish one cycle after last.
REQ-029 SHALL verify: (5,5)->(5,5) -> exactly one pixel (5,5), then finish, BUSY low next cycle.
REQ-030 SHALL verify: (10,2)->(2,10) with PIX_READY toggled randomly -> 9 pixels along anti-diagonal, each held stable while stalled, none duplicated or dropped.
REQ-031 SHALL verify: COORD_W=8, (255,0)->(0,255) and (0,255)->(255,0) -> 256 pixels each, no wrap, ending exactly at endpoint.
REQ-032 SHALL verify: ABORT asserted on 3rd pixel of (0,0)->(20,0) -> PIX_VALID low next cycle, no finish; new EN for (1,1)->(1,4) yields 4 correct pixels.
REQ-033 SHALL verify: ARESET pulsed mid-line and EN pulsed while BUSY -> outputs at reset values, EN while BUSY has no effect on the line in progress.
